sobel_window_ctrl: RTL
======================

# sobel_window_ctrl

Frame-level sequencer for the Sobel double-line-buffer datapath. Accepts a raster pixel stream, drives the line buffer's write enable and clear, and tracks column/row position. Flags which cycles present a complete 3x3 window, with its centre coordinate, and signals end of frame. Sits between the pixel source and the line buffer / Sobel kernel.

## Interface
- IMG_WIDTH, 640, pixels per line (≥3)
- IMG_HEIGHT, 480, lines per frame (≥3)
- COL_BITS, 10, width of column counters (2^COL_BITS ≥ IMG_WIDTH)
- ROW_BITS, 10, width of row counters (2^ROW_BITS ≥ IMG_HEIGHT)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  frame start request, sampled in IDLE only
- valid_i  in  1  pixel present on the datapath this cycle
- lb_done_i  in  1  line buffer `done_o` (both lines primed)
- lb_clr_o  out  1  one-cycle clear pulse to line buffer
- lb_we_o  out  1  line buffer write enable (combinational)
- win_valid_o  out  1  3x3 window complete (registered)
- win_col_o  out  COL_BITS  window centre column, valid with win_valid_o
- win_row_o  out  ROW_BITS  window centre row, valid with win_valid_o
- busy_o  out  1  high in FILL and RUN
- frame_done_o  out  1  one-cycle end-of-frame pulse
- sync_err_o  out  1  sticky: line buffer not primed when RUN entered

## Operation
- States: IDLE, FILL, RUN, DONE.
- IDLE:
  - start_i=1 → FILL. lb_clr_o=1 for that one cycle.
  - col, row and sync_err_o clear to 0.
  - valid_i ignored.
- Pixel acceptance:
  - A pixel is accepted in a cycle where the state is FILL or RUN and valid_i=1.
  - lb_we_o = accepted, combinational.
- Counters:
  - col increments on each accepted pixel.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - Counters hold while valid_i=0 (gaps allowed, any length).
- FILL → RUN: when the pixel at (row=2, col=0) is accepted.
  - If lb_done_i=0 in that cycle, sync_err_o sets.
  - sync_err_o stays set until the next start.
- Window flag: an accepted pixel at row≥2 and col≥2 completes a window.
  - Next cycle: win_valid_o=1, win_col_o=col-1, win_row_o=row-1.
- End of frame:
  - Acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1) → DONE.
  - Counters return to 0.
- DONE: frame_done_o=1 for exactly one cycle, then IDLE.
- Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
  - Border centres (row/col 0 or last) are never flagged.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0 (win_col_o and win_row_o 0; sync_err_o 0); counters 0.
- lb_we_o: zero latency (same cycle as valid_i).
- win_valid_o, win_col_o, win_row_o: 1-cycle latency after the completing pixel.
  - win_col_o and win_row_o hold their last value while win_valid_o=0.
- frame_done_o: asserted the cycle after the last pixel is accepted.
  - Coincides with the final win_valid_o.
- busy_o: high from the cycle after start_i is taken through the last-pixel cycle; low in DONE.
- start_i while busy or in DONE: ignored, no restart.
- rst=0 mid-frame:
  - Next edge → IDLE, counters 0, all outputs 0.
  - No frame_done_o pulse.
- valid_i in DONE or IDLE: not accepted, lb_we_o=0.
- start_i held high through DONE: a new frame begins at the first IDLE cycle.
- Counter arithmetic is unsigned. win_col_o/win_row_o never underflow because they are only updated when col≥2, row≥2.

## Test plan
- Reset/idle, W=5, H=4: assert rst=0 for 2 cycles, toggle valid_i without start → all outputs 0, lb_we_o stays 0.
- Continuous frame, W=5, H=4: start, then 20 consecutive valid pixels →
  - lb_clr_o once; lb_we_o high 20 cycles.
  - win_valid_o exactly 6 times. The first comes one cycle after pixel 12, centre (1,1); the last has centre (2,3).
  - frame_done_o one cycle after pixel 19; then IDLE.
- Gapped stream: same frame with valid_i low every other cycle → identical window sequence and centres; counters hold during gaps.
- Sync check: tie lb_done_i=0 → sync_err_o rises the cycle after pixel 10 is accepted and stays high until the next start. With lb_done_i=1, it stays 0.
- Mid-frame reset: rst=0 after pixel 8 → IDLE next cycle, no frame_done_o. A following full frame behaves exactly as in the continuous-frame scenario.
- Start while busy: pulse start_i at pixel 5 → ignored; window count still 6; one frame_done_o.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel double-line-buffer datapath: accepts a raster
// pixel stream, steers the line buffer and flags cycles carrying a full 3x3 window.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                valid_i,
    input  logic                lb_done_i,
    output logic                lb_clr_o,
    output logic                lb_we_o,
    output logic                win_valid_o,
    output logic [COL_BITS-1:0] win_col_o,
    output logic [ROW_BITS-1:0] win_row_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                sync_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
    localparam logic [COL_BITS-1:0] COL_TWO  = COL_BITS'(2);
    localparam logic [ROW_BITS-1:0] ROW_TWO  = ROW_BITS'(2);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;

    logic accept;
    logic start_take;
    logic col_wrap;
    logic last_pixel;
    logic fill_exit;
    logic win_hit;

    always_comb begin
        accept     = ((state == S_FILL) || (state == S_RUN)) && valid_i;
        start_take = (state == S_IDLE) && start_i;
        col_wrap   = (col == COL_LAST);
        last_pixel = accept && col_wrap && (row == ROW_LAST);
        // The first pixel of the third line means both earlier lines are buffered.
        fill_exit  = accept && (state == S_FILL) && (row == ROW_TWO) && (col == '0);
        win_hit    = accept && (row >= ROW_TWO) && (col >= COL_TWO);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_i) state_nxt = S_FILL;
            S_FILL: begin
                if (last_pixel)     state_nxt = S_DONE;
                else if (fill_exit) state_nxt = S_RUN;
            end
            S_RUN:  if (last_pixel) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            col         <= '0;
            row         <= '0;
            sync_err_o  <= 1'b0;
            win_valid_o <= 1'b0;
            win_col_o   <= '0;
            win_row_o   <= '0;
        end else begin
            state <= state_nxt;

            if (start_take) begin
                col        <= '0;
                row        <= '0;
                sync_err_o <= 1'b0;
            end else if (accept) begin
                if (col_wrap) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
                end else begin
                    col <= col + COL_ONE;
                end
            end

            if (fill_exit && !lb_done_i) begin
                sync_err_o <= 1'b1;
            end

            // The completing pixel is the bottom-right corner; the centre sits one up and one left.
            win_valid_o <= win_hit;
            if (win_hit) begin
                win_col_o <= col - COL_ONE;
                win_row_o <= row - ROW_ONE;
            end
        end
    end

    assign lb_we_o      = accept;
    assign lb_clr_o     = start_take;
    assign busy_o       = (state == S_FILL) || (state == S_RUN);
    assign frame_done_o = (state == S_DONE);

endmodule
